// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
//   Writer side of the 32x32 register file. Results from the single-cycle ALU
//   path are queued in a small FIFO; results from the multi-cycle load path are
//   offered directly. One winner per cycle is registered onto the regfile write
//   port. The load path normally has priority. A starvation counter limits how
//   many consecutive load wins can occur while ALU results are waiting. A 32-bit
//   busy scoreboard tracks destinations that have issued but not yet been
//   written back.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   issue_valid/rd/ready    instruction issue; ready is low while rd is busy
//   alu_valid/ready/rd/data ALU result handshake; ready = FIFO not full
//   mem_valid/ready/rd/data load result handshake; ready = not starving the FIFO
//   rf_load/dest/in         registered regfile write port
//   busy                    scoreboard; bit i = write to x_i outstanding
module rf_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            rf_load,
  output logic [4:0]      rf_dest,
  output logic [XLEN-1:0] rf_in,
  output logic [31:0]     busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIMIT);

  // FIFO state
  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Arbitration / output state
  logic [SW-1:0]   starve_q, starve_d;
  logic            rf_load_q, rf_load_d;
  logic [4:0]      rf_dest_q, rf_dest_d;
  logic [XLEN-1:0] rf_in_q, rf_in_d;
  logic [31:0]     busy_q, busy_d;

  logic fifo_nonempty;
  logic fifo_full;
  logic starve;
  logic alu_push;
  logic mem_win;
  logic fifo_pop;
  logic issue_fire;

  assign fifo_nonempty = (count_q != '0);
  assign fifo_full     = (count_q == FULL_CNT);
  assign starve        = fifo_nonempty & (starve_q == STARVE_MX);

  // Readiness comes only from registered state, so a dequeue on a full FIFO
  // frees its slot for the producer starting the following cycle.
  assign alu_ready   = ~fifo_full;
  assign mem_ready   = ~starve;
  assign issue_ready = (issue_rd == 5'd0) | ~busy_q[issue_rd];

  assign alu_push   = alu_valid & alu_ready;
  assign mem_win    = mem_valid & ~starve;
  assign fifo_pop   = ~mem_win & fifo_nonempty;
  assign issue_fire = issue_valid & issue_ready & (issue_rd != 5'd0);

  // FIFO pointer/count next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(alu_push) - CW'(fifo_pop);
    if (alu_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (fifo_pop) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Arbitration: load path first unless it has starved the FIFO long enough.
  // A winner targeting x0 is consumed but produces no write enable.
  always_comb begin
    rf_load_d = 1'b0;
    rf_dest_d = rf_dest_q;
    rf_in_d   = rf_in_q;
    starve_d  = '0;
    if (mem_win) begin
      rf_load_d = (mem_rd != 5'd0);
      rf_dest_d = mem_rd;
      rf_in_d   = mem_data;
      if (fifo_nonempty) starve_d = starve_q + SW'(1);
    end else if (fifo_nonempty) begin
      rf_load_d = (fifo_rd_q[rd_ptr_q] != 5'd0);
      rf_dest_d = fifo_rd_q[rd_ptr_q];
      rf_in_d   = fifo_data_q[rd_ptr_q];
    end
  end

  // Scoreboard: clear on writeback first, then set on issue so that a
  // same-index collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (rf_load_q) busy_d[rf_dest_q] = 1'b0;
    if (issue_fire) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rf_load_q <= 1'b0;
      rf_dest_q <= '0;
      rf_in_q   <= '0;
      busy_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rf_load_q <= rf_load_d;
      rf_dest_q <= rf_dest_d;
      rf_in_q   <= rf_in_d;
      busy_q    <= busy_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      fifo_rd_q[wr_ptr_q]   <= alu_rd;
      fifo_data_q[wr_ptr_q] <= alu_data;
    end
  end

  assign rf_load = rf_load_q;
  assign rf_dest = rf_dest_q;
  assign rf_in   = rf_in_q;
  assign busy    = busy_q;

endmodule
